// File: rtl/cdu_drive_pkg.sv
// Shared constants for the CDU / optics drive-pulse scheduler.
package cdu_drive_pkg;
  localparam int NAXES    = 5;
  localparam int MAGW     = 14;
  localparam int PTRW     = 3;

  localparam int AX_CDUX  = 0;
  localparam int AX_CDUY  = 1;
  localparam int AX_CDUZ  = 2;
  localparam int AX_TRUN  = 3;
  localparam int AX_SHAFT = 4;
endpackage

// File: rtl/drv_rr_arb.sv
// Round-robin pick of one requesting axis, starting after the last-served one.
module drv_rr_arb #(
  parameter int N    = cdu_drive_pkg::NAXES,
  parameter int PTRW = cdu_drive_pkg::PTRW
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            vld
);
  int best;

  // Distance of axis j from the search start is (j - ptr - 1) mod N; the
  // requester with the smallest distance wins.
  always_comb begin
    best = N;
    for (int j = 0; j < N; j++) begin
      if (req[j] && ((j - int'(ptr) - 1 + 2*N) % N) < best)
        best = (j - int'(ptr) - 1 + 2*N) % N;
    end
    gnt = '0;
    for (int j = 0; j < N; j++)
      gnt[j] = req[j] && (((j - int'(ptr) - 1 + 2*N) % N) == best);
    vld = |req;
  end
endmodule

// File: rtl/cdu_drive_sched.sv
// Drive-pulse scheduler: per-axis {sign, count} registers served one pulse
// per drive strobe, round-robin across enabled busy axes.
module cdu_drive_sched #(
  parameter int NAXES = cdu_drive_pkg::NAXES,
  parameter int MAGW  = cdu_drive_pkg::MAGW
) (
  input  logic             CLOCK,
  input  logic             rst_,
  input  logic             DRVSTB,
  input  logic             ABORT,
  input  logic             LDAX,
  input  logic [2:0]       LDSEL,
  input  logic             LDSGN,
  input  logic [MAGW-1:0]  LDMAG,
  input  logic [NAXES-1:0] ENAB,
  input  logic [2:0]       RDSEL,
  output logic [NAXES-1:0] DRVP,
  output logic [NAXES-1:0] DRVM,
  output logic [NAXES-1:0] BUSY,
  output logic [NAXES-1:0] DONE,
  output logic [MAGW-1:0]  RDCNT
);
  import cdu_drive_pkg::*;

  // Pointer reset value makes axis 0 the first one searched.
  localparam logic [PTRW-1:0] PTR_RST = PTRW'(NAXES - 1);

  logic [NAXES-1:0][MAGW-1:0] mag, mag_nxt;
  logic [NAXES-1:0]           sgn, sgn_nxt, busy_nxt;
  logic [NAXES-1:0]           ld_hit, srv, gnt, mag_one;
  logic [PTRW-1:0]            ptr, gidx;
  logic                       gvld, fire;

  drv_rr_arb #(.N(NAXES), .PTRW(PTRW)) u_arb (
    .req (BUSY & ENAB),
    .ptr (ptr),
    .gnt (gnt),
    .vld (gvld)
  );

  assign fire = DRVSTB & gvld;
  assign srv  = gnt & {NAXES{fire}};

  // Decode load target, final-count flag and grant index.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NAXES; i++) begin
      ld_hit[i]  = LDAX && (LDSEL == 3'(i));
      mag_one[i] = (mag[i] == MAGW'(1));
      if (gnt[i]) gidx = PTRW'(i);
    end
  end

  // Next count per axis: abort clears, a load overrides a same-edge service.
  always_comb begin
    for (int i = 0; i < NAXES; i++) begin
      mag_nxt[i] = mag[i];
      sgn_nxt[i] = sgn[i];
      if (ABORT) begin
        mag_nxt[i] = '0;
        sgn_nxt[i] = 1'b0;
      end else if (ld_hit[i]) begin
        mag_nxt[i] = LDMAG;
        sgn_nxt[i] = LDSGN;
      end else if (srv[i]) begin
        mag_nxt[i] = mag[i] - MAGW'(1);
      end
      busy_nxt[i] = (mag_nxt[i] != '0);
    end
  end

  // Axis state, registered pulses and round-robin pointer.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      mag  <= '0;
      sgn  <= '0;
      BUSY <= '0;
      DRVP <= '0;
      DRVM <= '0;
      DONE <= '0;
      ptr  <= PTR_RST;
    end else begin
      mag  <= mag_nxt;
      sgn  <= sgn_nxt;
      BUSY <= busy_nxt;
      if (ABORT) begin
        DRVP <= '0;
        DRVM <= '0;
        DONE <= '0;
        ptr  <= PTR_RST;
      end else begin
        DRVP <= srv & ~sgn;
        DRVM <= srv & sgn;
        DONE <= srv & ~ld_hit & mag_one;
        if (fire) ptr <= gidx;
      end
    end
  end

  // Readback mux; unused selects read zero.
  always_comb begin
    RDCNT = '0;
    for (int i = 0; i < NAXES; i++)
      if (RDSEL == 3'(i)) RDCNT = mag[i];
  end
endmodule

// File: tb/tb_cdu_drive_sched.sv
// Randomized + directed bench for cdu_drive_sched against a rule-level model.
module tb_cdu_drive_sched;
  localparam int N  = 5;
  localparam int MW = 14;

  logic          CLOCK = 1'b0;
  logic          rst_, DRVSTB, ABORT, LDAX, LDSGN;
  logic [2:0]    LDSEL, RDSEL;
  logic [MW-1:0] LDMAG, RDCNT;
  logic [N-1:0]  ENAB, DRVP, DRVM, BUSY, DONE;

  cdu_drive_sched #(.NAXES(N), .MAGW(MW)) dut (
    .CLOCK(CLOCK), .rst_(rst_), .DRVSTB(DRVSTB), .ABORT(ABORT),
    .LDAX(LDAX), .LDSEL(LDSEL), .LDSGN(LDSGN), .LDMAG(LDMAG),
    .ENAB(ENAB), .RDSEL(RDSEL), .DRVP(DRVP), .DRVM(DRVM),
    .BUSY(BUSY), .DONE(DONE), .RDCNT(RDCNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk, n_fail;
  int m[N];
  int s[N];
  int last;
  int loaded[N], discarded[N], pulses[N];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scheduler discards whatever remains on every axis.
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      discarded[i] += m[i];
      m[i] = 0;
      s[i] = 0;
    end
    last = N - 1;
  endtask

  function automatic int exp_rd();
    int rs;
    rs = int'(RDSEL);
    return (rs < N) ? m[rs] : 0;
  endfunction

  // One clock: drive inputs at negedge, predict, check after the edge.
  task automatic step(input bit stb, input bit ab, input bit ld,
                      input int sel, input bit sg, input int mg);
    int srvd, ep, em, ed, eb, idx;
    bit en[N];
    @(negedge CLOCK);
    DRVSTB = stb; ABORT = ab; LDAX = ld; LDSEL = 3'(sel);
    LDSGN = sg; LDMAG = MW'(mg);
    for (int i = 0; i < N; i++) en[i] = ENAB[i];
    ep = 0; em = 0; ed = 0; srvd = -1;
    if (ab) model_clear();
    else begin
      if (stb)
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (srvd < 0 && m[idx] != 0 && en[idx]) srvd = idx;
        end
      if (srvd >= 0) begin
        if (s[srvd] != 0) em = 1 << srvd; else ep = 1 << srvd;
        last = srvd;
      end
      if (srvd >= 0 && !(ld && sel == srvd)) begin
        m[srvd]--;
        if (m[srvd] == 0) ed = 1 << srvd;
      end
      if (ld && sel < N) begin
        discarded[sel] += m[sel] - ((srvd == sel) ? 1 : 0);
        loaded[sel] += mg;
        m[sel] = mg;
        s[sel] = sg;
      end
    end
    eb = 0;
    for (int i = 0; i < N; i++) if (m[i] != 0) eb |= (1 << i);
    @(posedge CLOCK);
    #1;
    check("drvp", int'(DRVP), ep);
    check("drvm", int'(DRVM), em);
    check("done", int'(DONE), ed);
    check("busy", int'(BUSY), eb);
    check("rdcnt", int'(RDCNT), exp_rd());
    check("onehot", int'($countones(DRVP | DRVM) <= 1), 1);
    for (int i = 0; i < N; i++) pulses[i] += int'(DRVP[i] | DRVM[i]);
  endtask

  int order[6] = '{1, 2, 4, 1, 2, 4};

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < N; i++) begin
      m[i] = 0; s[i] = 0; loaded[i] = 0; discarded[i] = 0; pulses[i] = 0;
    end
    last = N - 1;
    rst_ = 1'b0; DRVSTB = 0; ABORT = 0; LDAX = 0; LDSEL = '0; LDSGN = 0;
    LDMAG = '0; ENAB = '1; RDSEL = '0;
    #12;
    check("rst_busy", int'(BUSY), 0);
    check("rst_drv", int'(DRVP | DRVM | DONE), 0);
    @(negedge CLOCK) rst_ = 1'b1;

    // Axis 0, plus, three pulses, DONE on the last.
    step(0, 0, 1, 0, 0, 3);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("a0_done", int'(DONE), 1);
    check("a0_busy", int'(BUSY[0]), 0);

    // Three axes share the strobe in rotation.
    step(0, 0, 1, 1, 0, 2);
    step(0, 0, 1, 2, 0, 2);
    step(0, 0, 1, 4, 0, 2);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0, 0, 0);
      check("rr_order", int'(DRVP), 1 << order[k]);
    end
    for (int i = 0; i < N; i++) begin
      RDSEL = 3'(i); #1;
      check("rr_rdcnt", int'(RDCNT), 0);
    end

    // Enable freezes and resumes a minus-direction command.
    RDSEL = 3'd3;
    step(0, 0, 1, 3, 1, 5);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    ENAB = 5'b10111;
    repeat (4) step(1, 0, 0, 0, 0, 0);
    check("frz_rdcnt", int'(RDCNT), 3);
    ENAB = '1;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check("frz_done", int'(DONE), 8);

    // Reload on the serving edge: pulse issues, load wins.
    RDSEL = 3'd0;
    step(0, 0, 1, 0, 0, 2);
    step(1, 0, 1, 0, 0, 7);
    check("ld_win_p", int'(DRVP), 1);
    check("ld_win_cnt", int'(RDCNT), 7);

    // Abort mid-command, strobe on the same edge ignored.
    step(1, 1, 1, 2, 0, 4);
    check("abort_busy", int'(BUSY), 0);
    step(1, 0, 0, 0, 0, 0);
    check("abort_nopulse", int'(DRVP | DRVM), 0);

    // Asynchronous reset between edges.
    RDSEL = 3'd2;
    step(0, 0, 1, 2, 1, 5);
    step(1, 0, 0, 0, 0, 0);
    #2 rst_ = 1'b0;
    #1;
    model_clear();
    check("arst_busy", int'(BUSY), 0);
    check("arst_drv", int'(DRVP | DRVM | DONE), 0);
    check("arst_rdcnt", int'(RDCNT), 0);
    @(negedge CLOCK) rst_ = 1'b1;
    step(0, 0, 1, 4, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    check("arst_first", int'(DRVP), 16);

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 19) == 0) ENAB = N'($urandom);
      RDSEL = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 6));
    end

    for (int i = 0; i < N; i++)
      check("pulse_total", pulses[i], loaded[i] - discarded[i] - m[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
